// File: rtl/fifo_burst_reader_if.sv
// FIFO read-side and burst stream signals between fifo_burst_reader and its neighbours.
// master = the burst reader itself, slave = the FIFO/sink environment around it.
interface fifo_burst_reader_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 9
);
   logic [CNT_WIDTH-1:0]  fifo_fcounter;
   logic                  fifo_empty;
   logic                  fifo_r_enable;
   logic [DATA_WIDTH-1:0] fifo_r_data;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;
   logic                  burst_active;
   logic [15:0]           burst_count;

   modport master (
      input  fifo_fcounter, fifo_empty, fifo_r_data, m_ready,
      output fifo_r_enable, m_valid, m_data, m_last, burst_active, burst_count
   );

   modport slave (
      output fifo_fcounter, fifo_empty, fifo_r_data, m_ready,
      input  fifo_r_enable, m_valid, m_data, m_last, burst_active, burst_count
   );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a synchronous FIFO in fixed-length bursts onto a valid/ready stream,
// flushing partial residues after an idle timeout.
module fifo_burst_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 9,
   parameter int BURST_LEN  = 16,
   parameter int TIMEOUT    = 255
) (
   input logic                 clk,
   input logic                 reset,
   fifo_burst_reader_if.master bus
);
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_WIDTH-1:0] BURST_LEN_C = CNT_WIDTH'(BURST_LEN);
   localparam logic [CNT_WIDTH-1:0] ONE_C       = CNT_WIDTH'(1);
   localparam logic [TW-1:0]        TIMEOUT_C   = TW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      DRAIN
   } state_t;

   state_t                state;
   logic [CNT_WIDTH-1:0]  beats_left;
   logic [TW-1:0]         idle_cnt;
   logic                  active;
   logic [15:0]           count;

   logic                  inflight;
   logic                  inflight_last;
   logic [DATA_WIDTH-1:0] buf_data [2];
   logic                  buf_last [2];
   logic                  head;
   logic [1:0]            buf_occ;

   logic                  rd_en;
   logic                  pop;
   logic                  tail;
   logic [1:0]            outstanding;

   // Credit counts both buffered beats and the read still in the FIFO pipeline,
   // so a 2-entry buffer can never be overrun regardless of m_ready.
   always_comb begin
      outstanding = buf_occ + {1'b0, inflight};
      rd_en       = (state == BURST) && (beats_left != '0) && !bus.fifo_empty
                    && (outstanding < 2'd2);
      pop         = (buf_occ != 2'd0) && bus.m_ready;
      tail        = head ^ buf_occ[0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         beats_left <= '0;
         idle_cnt   <= '0;
         active     <= 1'b0;
         count      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.fifo_fcounter >= BURST_LEN_C) begin
                  state      <= BURST;
                  beats_left <= BURST_LEN_C;
                  idle_cnt   <= '0;
                  active     <= 1'b1;
               end else if ((TIMEOUT != 0) && (idle_cnt == TIMEOUT_C)
                            && (bus.fifo_fcounter != '0)) begin
                  state      <= BURST;
                  beats_left <= bus.fifo_fcounter;
                  idle_cnt   <= '0;
                  active     <= 1'b1;
               end else if (bus.fifo_fcounter == '0) begin
                  idle_cnt <= '0;
               end else if (idle_cnt != TIMEOUT_C) begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            BURST: begin
               if (rd_en) begin
                  beats_left <= beats_left - 1'b1;
                  if (beats_left == ONE_C) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (pop && buf_last[head]) begin
                  state  <= IDLE;
                  active <= 1'b0;
                  count  <= count + 16'd1;
               end
            end
            default: begin
               state  <= IDLE;
               active <= 1'b0;
            end
         endcase
      end
   end

   // A capture and a pop on the same edge write the tail slot while the head
   // advances into it, leaving the occupancy unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         head          <= 1'b0;
         buf_occ       <= 2'd0;
         for (int unsigned i = 0; i < 2; i++) begin
            buf_data[i] <= '0;
            buf_last[i] <= 1'b0;
         end
      end else begin
         inflight      <= rd_en;
         inflight_last <= rd_en && (beats_left == ONE_C);
         if (inflight) begin
            buf_data[tail] <= bus.fifo_r_data;
            buf_last[tail] <= inflight_last;
         end
         if (pop) begin
            head <= ~head;
         end
         buf_occ <= buf_occ + {1'b0, inflight} - {1'b0, pop};
      end
   end

   assign bus.fifo_r_enable = rd_en;
   assign bus.m_valid       = (buf_occ != 2'd0);
   assign bus.m_data        = buf_data[head];
   assign bus.m_last        = (buf_occ != 2'd0) && buf_last[head];
   assign bus.burst_active  = active;
   assign bus.burst_count   = count;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: FIFO model, spec-level burst model,
// directed scenarios with literal expectations, then a randomized soak.
module tb_fifo_burst_reader;
   localparam int DW = 8;
   localparam int CW = 9;
   localparam int BL = 16;
   localparam int TO = 255;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fifo_burst_reader_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

   fifo_burst_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.master)
   );

   int checks = 0;
   int failures = 0;
   int cycle = 0;

   logic [7:0] fifo_q[$];
   logic [7:0] sent_q[$];
   logic [7:0] pend_q[$];
   logic [7:0] wbyte;
   int ready_mode = 0;
   logic s_rd = 1'b0;
   logic s_reset = 1'b1;

   bit m_idle = 1'b1;
   int idle_cnt = 0;
   int remaining = 0;
   int rd_left = 0;
   logic [15:0] m_count = '0;
   int issued = 0;
   int accepted = 0;
   int total_beats = 0;
   int total_reads = 0;
   int active_cycles = 0;
   int start_cycle = 0;
   int first_valid_lat = -1;
   bit lat_pending = 1'b0;
   int burst_lens[$];
   logic [7:0] last_tagged = '0;
   bit prev_stall = 1'b0;
   logic [7:0] prev_data = '0;
   logic prev_last = 1'b0;
   int first_wr_cycle = -1;
   int fc;
   logic [7:0] exp_d;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   always @(posedge clk) cycle <= cycle + 1;

   // FIFO environment: applies the read/write of the edge just passed.
   always @(posedge clk) begin
      #1;
      if (s_reset) begin
         fifo_q.delete();
         sent_q.delete();
      end else begin
         if (s_rd && fifo_q.size() > 0) bus.fifo_r_data = fifo_q.pop_front();
         if (pend_q.size() > 0 && fifo_q.size() < 511) begin
            wbyte = pend_q.pop_front();
            fifo_q.push_back(wbyte);
            sent_q.push_back(wbyte);
            if (first_wr_cycle < 0) first_wr_cycle = cycle;
         end
      end
      bus.fifo_fcounter = CW'(fifo_q.size());
      bus.fifo_empty    = (fifo_q.size() == 0);
      case (ready_mode)
         0: bus.m_ready = 1'b1;
         1: bus.m_ready = ~bus.m_ready;
         default: bus.m_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   // Reference model and per-cycle compare, evaluated mid-cycle.
   always @(negedge clk) begin
      s_rd    = bus.fifo_r_enable;
      s_reset = reset;
      if (reset) begin
         m_idle      = 1'b1;
         idle_cnt    = 0;
         remaining   = 0;
         rd_left     = 0;
         m_count     = '0;
         issued      = 0;
         accepted    = 0;
         prev_stall  = 1'b0;
         lat_pending = 1'b0;
      end else begin
         check("burst_active", bus.burst_active, !m_idle);
         check("burst_count", bus.burst_count, m_count);
         check("rd_when_empty", bus.fifo_r_enable && bus.fifo_empty, 0);
         check("last_without_valid", bus.m_last && !bus.m_valid, 0);
         if (bus.burst_active) active_cycles++;
         if (prev_stall) begin
            check("hold_valid", bus.m_valid, 1);
            check("hold_data", bus.m_data, prev_data);
            check("hold_last", bus.m_last, prev_last);
         end
         if (m_idle) begin
            check("rd_in_idle", bus.fifo_r_enable, 0);
            check("valid_in_idle", bus.m_valid, 0);
            fc = fifo_q.size();
            if (fc >= BL || (TO != 0 && idle_cnt == TO && fc != 0)) begin
               m_idle      = 1'b0;
               remaining   = (fc >= BL) ? BL : fc;
               rd_left     = remaining;
               idle_cnt    = 0;
               start_cycle = cycle + 1;
               lat_pending = 1'b1;
               burst_lens.push_back(remaining);
            end else if (fc == 0) begin
               idle_cnt = 0;
            end else if (idle_cnt < TO) begin
               idle_cnt++;
            end
         end else begin
            if (bus.fifo_r_enable) begin
               check("read_budget", rd_left > 0, 1);
               rd_left--;
            end
            if (lat_pending && bus.m_valid) begin
               first_valid_lat = cycle - start_cycle;
               lat_pending = 1'b0;
            end
            if (bus.m_valid && bus.m_ready) begin
               check("beat_expected", sent_q.size() > 0, 1);
               exp_d = (sent_q.size() > 0) ? sent_q.pop_front() : 8'h00;
               check("beat_data", bus.m_data, exp_d);
               check("beat_last", bus.m_last, remaining == 1);
               if (bus.m_last) last_tagged = bus.m_data;
               remaining--;
               total_beats++;
               if (remaining == 0) begin
                  m_idle = 1'b1;
                  m_count++;
                  idle_cnt = 0;
               end
            end
         end
         if (bus.fifo_r_enable) begin
            issued++;
            total_reads++;
            check("outstanding", (issued - accepted) <= 2, 1);
         end
         if (bus.m_valid && bus.m_ready) accepted++;
         prev_stall = bus.m_valid && !bus.m_ready;
         prev_data  = bus.m_data;
         prev_last  = bus.m_last;
      end
   end

   task automatic do_reset();
      @(posedge clk); #2;
      reset = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
      burst_lens.delete();
      first_wr_cycle  = -1;
      first_valid_lat = -1;
      last_tagged     = '0;
   endtask

   task automatic wait_quiet(input int budget, input string tag);
      int n = 0;
      while (!(pend_q.size() == 0 && fifo_q.size() == 0 && sent_q.size() == 0 && m_idle)
             && n < budget) begin
         @(posedge clk); #2;
         n++;
      end
      check({"quiet_", tag}, n < budget, 1);
   endtask

   task automatic check_lens(input string tag, input int e0, input int e1, input int e2, input int n);
      int exp_l[3];
      exp_l[0] = e0; exp_l[1] = e1; exp_l[2] = e2;
      check({tag, "_burst_num"}, burst_lens.size(), n);
      for (int i = 0; i < n && i < burst_lens.size(); i++) check({tag, "_burst_len"}, burst_lens[i], exp_l[i]);
   endtask

   int base_beats, base_reads, base_active, written, gap, len;

   initial begin
      bus.fifo_fcounter = '0;
      bus.fifo_empty    = 1'b1;
      bus.fifo_r_data   = '0;
      bus.m_ready       = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check("rst_valid", bus.m_valid, 0);
      check("rst_last", bus.m_last, 0);
      check("rst_rd", bus.fifo_r_enable, 0);
      check("rst_active", bus.burst_active, 0);
      check("rst_data", bus.m_data, 0);
      check("rst_count", bus.burst_count, 0);
      reset = 1'b0;

      // 1: single full burst, sink always ready
      do_reset(); ready_mode = 0;
      base_beats = total_beats; base_reads = total_reads;
      for (int i = 0; i < 16; i++) pend_q.push_back(8'(i));
      wait_quiet(400, "t1");
      check("t1_count", bus.burst_count, 1);
      check("t1_beats", total_beats - base_beats, 16);
      check("t1_reads", total_reads - base_reads, 16);
      check("t1_last_on", last_tagged, 8'h0F);
      check("t1_first_valid_lat", first_valid_lat, 2);
      check_lens("t1", 16, 0, 0, 1);

      // 2: same burst with toggling backpressure
      do_reset(); ready_mode = 1;
      base_beats = total_beats; base_reads = total_reads;
      for (int i = 0; i < 16; i++) pend_q.push_back(8'(i));
      wait_quiet(400, "t2");
      check("t2_count", bus.burst_count, 1);
      check("t2_beats", total_beats - base_beats, 16);
      check("t2_reads", total_reads - base_reads, 16);
      check("t2_last_on", last_tagged, 8'h0F);

      // 3: five-byte residue flushed by timeout
      do_reset(); ready_mode = 0;
      base_beats = total_beats;
      for (int i = 0; i < 5; i++) pend_q.push_back(8'hA0 + 8'(i));
      wait_quiet(700, "t3");
      check("t3_count", bus.burst_count, 1);
      check("t3_beats", total_beats - base_beats, 5);
      check("t3_last_on", last_tagged, 8'hA4);
      check("t3_flush_delay", start_cycle - first_wr_cycle, 256);
      check_lens("t3", 5, 0, 0, 1);

      // 4: two full bursts plus a flushed tail
      do_reset(); ready_mode = 0;
      base_beats = total_beats;
      for (int i = 0; i < 40; i++) pend_q.push_back(8'(i + 16));
      wait_quiet(1200, "t4");
      check("t4_count", bus.burst_count, 3);
      check("t4_beats", total_beats - base_beats, 40);
      check_lens("t4", 16, 16, 8, 3);

      // 5: reset after beat 7 of the second burst
      do_reset(); ready_mode = 0;
      base_beats = total_beats;
      for (int i = 0; i < 32; i++) pend_q.push_back(8'(i + 64));
      begin
         int n = 0;
         while (total_beats - base_beats < 23 && n < 300) begin
            @(posedge clk); #2;
            n++;
         end
         check("t5_reach_beat", n < 300, 1);
      end
      check("t5_count_before", bus.burst_count, 1);
      reset = 1'b1;
      @(posedge clk); #2;
      check("t5_valid", bus.m_valid, 0);
      check("t5_rd", bus.fifo_r_enable, 0);
      check("t5_active", bus.burst_active, 0);
      check("t5_count", bus.burst_count, 0);
      reset = 1'b0;

      // 6: empty FIFO for 1000 cycles
      do_reset(); ready_mode = 2;
      base_reads = total_reads; base_active = active_cycles;
      repeat (1000) @(posedge clk);
      #2;
      check("t6_reads", total_reads - base_reads, 0);
      check("t6_active", active_cycles - base_active, 0);

      // randomized soak: random burst sizes, gaps and backpressure
      do_reset(); ready_mode = 2;
      base_beats = total_beats; written = 0;
      for (int r = 0; r < 30; r++) begin
         len = $urandom_range(1, 40);
         for (int i = 0; i < len; i++) pend_q.push_back(8'($urandom));
         written += len;
         gap = ($urandom_range(0, 4) == 0) ? $urandom_range(260, 320) : $urandom_range(0, 20);
         begin
            int n = 0;
            while (pend_q.size() != 0 && n < 400) begin
               @(posedge clk); #2;
               n++;
            end
         end
         repeat (gap) @(posedge clk);
         #2;
      end
      wait_quiet(3000, "rand");
      check("rand_beats", total_beats - base_beats, written);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3ms;
      failures++;
      $display("FAIL watchdog: got no completion expected finish before 3ms");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end
endmodule
